memory_rd_seq: RTL

//  Read-side sequencer for the 8-bit x 64-entry sample memory (memory_in). On a start

---
 rtl/memory_rd_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/memory_rd_seq.sv
// memory_rd_seq: read-side sequencer for the 8-bit x 64-entry sample memory.
// On start it reads count consecutive words from base_addr, one read in
// flight at a time, and streams each word out over a valid/ready handshake.
// Optional feature macro: MEM_RD_SUM_EN adds a running sum output of the
// words handed off during the current transfer.
module memory_rd_seq #(
   parameter int DW = 8,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   count,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic          busy,
   output logic          done
`ifdef MEM_RD_SUM_EN
   ,
   output logic [DW+AW-1:0] sum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LOAD,
      S_SEND,
      S_FIN
   } state_t;

   state_t      state, state_nxt;
   logic [AW:0] remaining;   // words still to hand off, including the current one
   logic        zero_done;   // done pulse for a count==0 request, issued from IDLE
   logic        start_ok;
   logic        handshake;

   // Start is only honoured in IDLE; a word leaves only from SEND.
   assign start_ok  = (state == S_IDLE) && start;
   assign handshake = (state == S_SEND) && rd_ready;

   // The sequencer never writes the memory.
   assign mem_wr = 1'b0;

   // State register.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; blocking = here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start && (count != '0)) state_nxt = S_ADDR;
         S_ADDR: state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_SEND;
         S_SEND: begin
            if (rd_ready) begin
               if (remaining == 1) state_nxt = S_FIN;
               else                state_nxt = S_ADDR;
            end
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy     = (state != S_IDLE);
      rd_valid = (state == S_SEND);
      done     = (state == S_FIN) || zero_done;
   end

   // Datapath: read address, captured word and remaining-word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr  <= '0;
         rd_data   <= '0;
         remaining <= '0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= start_ok && (count == '0);
         if (start_ok && (count != '0)) begin
            mem_addr  <= base_addr;
            remaining <= count;
         end
         if (state == S_LOAD) rd_data <= mem_rdata;
         if (handshake) begin
            remaining <= remaining - 1'b1;
            // Last word keeps its address; otherwise step on, wrapping 63 -> 0.
            if (remaining != 1) mem_addr <= mem_addr + 1'b1;
         end
      end
   end

`ifdef MEM_RD_SUM_EN
   // Running sum of handed-off words; held after done until the next start.
   always_ff @(posedge clk) begin
      if (rst)            sum <= '0;
      else if (start_ok)  sum <= '0;
      else if (handshake) sum <= sum + {{AW{1'b0}}, rd_data};
   end
`endif

endmodule
